// File: rtl/stg_runtime_monitor.sv
// stg_runtime_monitor: state-graph runtime monitor with a loadable transition table.
// Optional coverage ports (visited, trans_hit) are enabled by STG_RUNTIME_MONITOR_COVER_EN.
module stg_runtime_monitor #(
    parameter int N_SIG       = 8,
    parameter int N_STATES    = 16,
    parameter int N_TRANS     = 32,
    parameter int ENA_W       = 8,
    parameter int INIT_STATE  = 0,
    parameter int CNT_W       = 16,
    parameter int HALT_ON_ERR = 0,
    localparam int STATE_W    = $clog2(N_STATES),
    localparam int SIG_W      = $clog2(N_SIG),
    localparam int ADDR_W     = $clog2(N_TRANS),
    localparam int ENTRY_W    = 2*STATE_W + SIG_W + 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mon_en,
    input  logic [N_SIG-1:0]   is_output,
    input  logic [N_SIG-1:0]   sig,
    input  logic [ENA_W-1:0]   ena,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [ENTRY_W-1:0] cfg_entry,
    output logic [STATE_W-1:0] state,
    output logic               err_valid,
    output logic [2:0]         err_code,
    output logic [SIG_W-1:0]   err_sig,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   err_count
`ifdef STG_RUNTIME_MONITOR_COVER_EN
    ,
    output logic [N_STATES-1:0] visited,
    output logic [N_TRANS-1:0]  trans_hit
`endif
);

    typedef struct packed {
        logic               valid;
        logic [STATE_W-1:0] from;
        logic [SIG_W-1:0]   idx;
        logic               dir;
        logic [STATE_W-1:0] to;
    } entry_t;

    typedef enum logic [2:0] {
        E_NONE  = 3'd0,
        E_IN    = 3'd1,
        E_OUT   = 3'd2,
        E_MULTI = 3'd3,
        E_ENA   = 3'd4,
        E_STAB  = 3'd5
    } err_e;

    localparam bit HALT = (HALT_ON_ERR != 0);
    localparam logic [STATE_W-1:0] INIT_S = STATE_W'(INIT_STATE);

    entry_t             tbl [N_TRANS];
    logic [N_SIG-1:0]   prev_sig;
    logic [ENA_W-1:0]   prev_ena;
    logic               running;
    logic               halted;

    logic [N_SIG-1:0]   d;
    logic [SIG_W-1:0]   low_idx;
    logic               found;
    logic [STATE_W-1:0] hit_to;
    err_e               chk_code;
    logic [SIG_W-1:0]   chk_sig;
    logic               move;
    logic               start;
    logic               active;
`ifdef STG_RUNTIME_MONITOR_COVER_EN
    logic [ADDR_W-1:0]  hit_addr;
`endif

    assign start  = mon_en && !running;
    assign active = mon_en && running && !(HALT && halted);

    // Classify the sampled edge: enable faults first, then signal changes vs. the table.
    always_comb begin
        d        = sig ^ prev_sig;
        low_idx  = '0;
        found    = 1'b0;
        hit_to   = state;
        chk_code = E_NONE;
        chk_sig  = '0;
        move     = 1'b0;
`ifdef STG_RUNTIME_MONITOR_COVER_EN
        hit_addr = '0;
`endif
        for (int i = N_SIG-1; i >= 0; i--) begin
            if (d[i]) low_idx = SIG_W'(i);
        end
        for (int t = N_TRANS-1; t >= 0; t--) begin
            if (tbl[t].valid && tbl[t].from == state &&
                tbl[t].idx == low_idx && tbl[t].dir == sig[low_idx] &&
                int'(tbl[t].from) < N_STATES &&
                int'(tbl[t].to) < N_STATES) begin
                found  = 1'b1;
                hit_to = tbl[t].to;
`ifdef STG_RUNTIME_MONITOR_COVER_EN
                hit_addr = ADDR_W'(t);
`endif
            end
        end
        if ((ena & (ena - 1'b1)) != '0) begin
            chk_code = E_ENA;
        end else if (prev_ena != '0 && ena != '0 && ena != prev_ena) begin
            chk_code = E_STAB;
        end else if ($countones(d) > 1) begin
            chk_code = E_MULTI;
            chk_sig  = low_idx;
        end else if (d != '0) begin
            if (found) begin
                move = 1'b1;
            end else begin
                chk_code = is_output[low_idx] ? E_OUT : E_IN;
                chk_sig  = low_idx;
            end
        end
    end

    // Table load, run control, state tracking and error reporting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int t = 0; t < N_TRANS; t++) tbl[t] <= '0;
            state      <= INIT_S;
            err_valid  <= 1'b0;
            err_code   <= E_NONE;
            err_sig    <= '0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            prev_sig   <= '0;
            prev_ena   <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            if (cfg_we && !mon_en) tbl[cfg_addr] <= entry_t'(cfg_entry);
            running   <= mon_en;
            err_valid <= 1'b0;
            if (start) begin
                state      <= INIT_S;
                prev_sig   <= sig;
                prev_ena   <= ena;
                err_sticky <= 1'b0;
                err_count  <= '0;
                halted     <= 1'b0;
            end else if (mon_en) begin
                prev_sig <= sig;
                prev_ena <= ena;
                if (active) begin
                    if (chk_code != E_NONE) begin
                        err_valid  <= 1'b1;
                        err_code   <= chk_code;
                        err_sig    <= chk_sig;
                        err_sticky <= 1'b1;
                        if (err_count != {CNT_W{1'b1}})
                            err_count <= err_count + 1'b1;
                        if (HALT) halted <= 1'b1;
                    end else if (move) begin
                        state <= hit_to;
                    end
                end
            end
        end
    end

`ifdef STG_RUNTIME_MONITOR_COVER_EN
    // Record states entered and table entries used during the current run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            visited   <= '0;
            trans_hit <= '0;
        end else if (start) begin
            visited             <= '0;
            visited[INIT_STATE] <= 1'b1;
            trans_hit           <= '0;
        end else if (active && chk_code == E_NONE && move) begin
            visited[hit_to]     <= 1'b1;
            trans_hit[hit_addr] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stg_runtime_monitor.sv
// Testbench for stg_runtime_monitor: directed test-plan sequence plus random
// stimulus, checked every cycle against a behavioural model (three parameter sets).
module tb_stg_runtime_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     = 1'b0;
    logic        mon_en    = 1'b0;
    logic [7:0]  is_output = 8'h00;
    logic [7:0]  sig       = 8'h00;
    logic [7:0]  ena       = 8'h00;
    logic        cfg_we    = 1'b0;
    logic [4:0]  cfg_addr  = 5'd0;
    logic [12:0] cfg_entry = 13'd0;

    logic [3:0]  st0, st1, st2;
    logic        v0, v1, v2;
    logic [2:0]  ec0, ec1, ec2;
    logic [2:0]  es0, es1, es2;
    logic        sk0, sk1, sk2;
    logic [15:0] c0;
    logic [1:0]  c1;
    logic [15:0] c2;
`ifdef STG_RUNTIME_MONITOR_COVER_EN
    logic [15:0] vis0, vis1, vis2;
    logic [31:0] th0, th1, th2;
`endif

    stg_runtime_monitor u0 (
        .clk(clk), .reset(reset), .mon_en(mon_en), .is_output(is_output),
        .sig(sig), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_entry(cfg_entry), .state(st0), .err_valid(v0), .err_code(ec0),
        .err_sig(es0), .err_sticky(sk0), .err_count(c0)
`ifdef STG_RUNTIME_MONITOR_COVER_EN
        , .visited(vis0), .trans_hit(th0)
`endif
    );

    stg_runtime_monitor #(.CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .mon_en(mon_en), .is_output(is_output),
        .sig(sig), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_entry(cfg_entry), .state(st1), .err_valid(v1), .err_code(ec1),
        .err_sig(es1), .err_sticky(sk1), .err_count(c1)
`ifdef STG_RUNTIME_MONITOR_COVER_EN
        , .visited(vis1), .trans_hit(th1)
`endif
    );

    stg_runtime_monitor #(.HALT_ON_ERR(1)) u2 (
        .clk(clk), .reset(reset), .mon_en(mon_en), .is_output(is_output),
        .sig(sig), .ena(ena), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_entry(cfg_entry), .state(st2), .err_valid(v2), .err_code(ec2),
        .err_sig(es2), .err_sticky(sk2), .err_count(c2)
`ifdef STG_RUNTIME_MONITOR_COVER_EN
        , .visited(vis2), .trans_hit(th2)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       run;
        bit       halted;
        int       st;
        bit       v;
        int       code;
        int       es;
        bit       sticky;
        int       cnt;
        bit [7:0] ps;
        bit [7:0] pe;
    } mdl_t;

    mdl_t m0, m1, m2;
    bit tv [32];
    int tf [32], ti [32], td [32], tt [32];

    function automatic mdl_t step(mdl_t a, int cmax, bit halt);
        mdl_t m;
        int   ch[$];
        int   code, es, nst;
        bit   found;
        m = a;
        if (!reset) begin
            m.run = 0; m.halted = 0; m.st = 0; m.v = 0; m.code = 0;
            m.es = 0; m.sticky = 0; m.cnt = 0; m.ps = 0; m.pe = 0;
            return m;
        end
        m.v = 0;
        if (!mon_en) begin
            m.run = 0;
            return m;
        end
        if (!m.run) begin
            m.run = 1; m.st = 0; m.ps = sig; m.pe = ena;
            m.sticky = 0; m.cnt = 0; m.halted = 0;
            return m;
        end
        for (int i = 0; i < 8; i++) if (sig[i] != m.ps[i]) ch.push_back(i);
        code = 0; es = 0; nst = m.st; found = 0;
        if ($countones(ena) > 1) code = 4;
        else if (m.pe != 0 && ena != 0 && ena != m.pe) code = 5;
        else if (ch.size() > 1) begin code = 3; es = ch[0]; end
        else if (ch.size() == 1) begin
            for (int t = 0; t < 32 && !found; t++) begin
                if (tv[t] && tf[t] == m.st && ti[t] == ch[0] &&
                    td[t] == int'(sig[ch[0]])) begin
                    found = 1; nst = tt[t];
                end
            end
            if (!found) begin code = is_output[ch[0]] ? 2 : 1; es = ch[0]; end
        end
        m.ps = sig;
        m.pe = ena;
        if (halt && m.halted) return m;
        if (code != 0) begin
            m.v = 1; m.code = code; m.es = es; m.sticky = 1;
            if (m.cnt < cmax) m.cnt++;
            if (halt) m.halted = 1;
        end else begin
            m.st = nst;
        end
        return m;
    endfunction

    // Advance the model on every edge and compare all three instances just after it.
    always @(posedge clk) begin
        m0 = step(m0, 65535, 0);
        m1 = step(m1, 3, 0);
        m2 = step(m2, 65535, 1);
        if (!reset) begin
            for (int t = 0; t < 32; t++) tv[t] = 0;
        end else if (cfg_we && !mon_en) begin
            tv[cfg_addr] = cfg_entry[12];
            tf[cfg_addr] = int'(cfg_entry[11:8]);
            ti[cfg_addr] = int'(cfg_entry[7:5]);
            td[cfg_addr] = int'(cfg_entry[4]);
            tt[cfg_addr] = int'(cfg_entry[3:0]);
        end
        #1;
        chk("m0_state", 32'(st0), m0.st);
        chk("m0_valid", 32'(v0), 32'(m0.v));
        chk("m0_code", 32'(ec0), m0.code);
        chk("m0_sig", 32'(es0), m0.es);
        chk("m0_sticky", 32'(sk0), 32'(m0.sticky));
        chk("m0_count", 32'(c0), m0.cnt);
        chk("m1_state", 32'(st1), m1.st);
        chk("m1_valid", 32'(v1), 32'(m1.v));
        chk("m1_code", 32'(ec1), m1.code);
        chk("m1_count", 32'(c1), m1.cnt);
        chk("m2_state", 32'(st2), m2.st);
        chk("m2_valid", 32'(v2), 32'(m2.v));
        chk("m2_code", 32'(ec2), m2.code);
        chk("m2_sticky", 32'(sk2), 32'(m2.sticky));
        chk("m2_count", 32'(c2), m2.cnt);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [12:0] mk(int vld, int from, int idx, int dir, int to);
        return {1'(vld), 4'(from), 3'(idx), 1'(dir), 4'(to)};
    endfunction

    task automatic wr(input int a, input logic [12:0] e);
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_entry = e;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic load_4phase();
        wr(0, mk(1, 0, 0, 1, 1));
        wr(1, mk(1, 1, 1, 1, 2));
        wr(2, mk(1, 2, 0, 0, 3));
        wr(3, mk(1, 3, 1, 0, 0));
    endtask

    task automatic restart();
        mon_en = 1'b0;
        cyc();
        mon_en = 1'b1;
        cyc();
    endtask

    initial begin
        int r;
        cyc(); cyc();
        chk("rst_state", 32'(st0), 0);
        chk("rst_count", 32'(c0), 0);
        chk("rst_sticky", 32'(sk0), 0);
        chk("rst_valid", 32'(v0), 0);
        reset = 1'b1;
        load_4phase();
        is_output = 8'h02;
        mon_en = 1'b1;
        cyc();
        sig = 8'h01; cyc();
        chk("ph_req_rise", 32'(st0), 1);
        sig = 8'h03; cyc();
        chk("ph_ack_rise", 32'(st0), 2);
        sig = 8'h02; cyc();
        chk("ph_req_fall", 32'(st0), 3);
        sig = 8'h00; cyc();
        chk("ph_ack_fall", 32'(st0), 0);
        chk("ph_count", 32'(c0), 0);
        sig = 8'h02; cyc();
        chk("ill_out_valid", 32'(v0), 1);
        chk("ill_out_code", 32'(ec0), 2);
        chk("ill_out_sig", 32'(es0), 1);
        chk("ill_out_state", 32'(st0), 0);
        chk("ill_out_sticky", 32'(sk0), 1);
        cyc();
        chk("pulse_one_cycle", 32'(v0), 0);
        chk("code_hold", 32'(ec0), 2);

        sig = 8'h00; restart();
        sig = 8'h01; cyc();
        sig = 8'h02; cyc();
        chk("multi_code", 32'(ec0), 3);
        chk("multi_sig", 32'(es0), 0);
        chk("multi_state", 32'(st0), 1);
        ena = 8'h03; cyc();
        chk("ena_multi", 32'(ec0), 4);
        ena = 8'h00; cyc();
        ena = 8'h01; cyc();
        ena = 8'h02; cyc();
        chk("ena_unstable", 32'(ec0), 5);
        chk("ena_unstable_v", 32'(v0), 1);
        ena = 8'h00; cyc();
        ena = 8'h02; cyc();
        chk("ena_via_zero", 32'(v0), 0);
        ena = 8'h00;

        sig = 8'h00; restart();
        for (int k = 0; k < 5; k++) begin
            sig = sig ^ 8'h02;
            cyc();
        end
        chk("cnt16_five", 32'(c0), 5);
        chk("cnt2_sat", 32'(c1), 3);
        chk("halt_count", 32'(c2), 1);
        sig = 8'h03; cyc();
        chk("legal_after_err", 32'(st0), 1);
        chk("halt_frozen", 32'(st2), 0);
        chk("halt_no_pulse", 32'(v2), 0);
        restart();
        chk("halt_restart_st", 32'(st2), 0);
        chk("halt_restart_cnt", 32'(c2), 0);
        chk("halt_restart_stk", 32'(sk2), 0);

        wr(4, mk(1, 0, 1, 1, 1));
        sig = 8'h00; restart();
        sig = 8'h02; cyc();
        chk("cfg_ignored_code", 32'(ec0), 2);
        chk("cfg_ignored_st", 32'(st0), 0);

        reset = 1'b0; cyc();
        chk("midrst_state", 32'(st0), 0);
        chk("midrst_count", 32'(c0), 0);
        chk("midrst_sticky", 32'(sk0), 0);
        reset = 1'b1;
        sig = 8'h00; cyc();
        sig = 8'h01; cyc();
        chk("midrst_tbl_gone", 32'(ec0), 1);
        chk("midrst_tbl_st", 32'(st0), 0);

        // Random phase.
        mon_en = 1'b0;
        reset = 1'b0; cyc();
        reset = 1'b1;
        load_4phase();
        for (int a = 4; a < 32; a++)
            wr(a, mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 3)));
        is_output = 8'($urandom);
        mon_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60) sig[$urandom_range(0, 7)] ^= 1'b1;
            else if (r < 70) sig = sig ^ 8'(1 << $urandom_range(0, 7)) ^ 8'(1 << $urandom_range(0, 7));
            r = $urandom_range(0, 99);
            if (r < 5) ena = 8'h00;
            else if (r < 10) ena = 8'(1 << $urandom_range(0, 7));
            else if (r < 13) ena = 8'($urandom);
            if ($urandom_range(0, 99) < 2) mon_en = ~mon_en;
            cfg_we = ($urandom_range(0, 99) < 3);
            cfg_addr = 5'($urandom);
            cfg_entry = mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                           $urandom_range(0, 1), $urandom_range(0, 3));
            reset = ($urandom_range(0, 499) != 0);
            cyc();
            if (!reset) begin
                reset = 1'b1;
                cfg_we = 1'b0;
                mon_en = 1'b0;
                load_4phase();
                mon_en = 1'b1;
            end
        end
        cfg_we = 1'b0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
